nes_receiver: RTL

- Serial front end for an NES gamepad. Drives the pad's latch and clock lines and shifts in the 8 button bits.
- Presents a registered, active-high button word to the input controller stage.
- Sits between the uio pins (NES_Latch/NES_Clk out, NES_Data in) and InputController. One poll per frame, triggered by frame_end from the sync generator.

---
 rtl/nes_receiver.sv | 76 +++++++
 1 files changed

// File: rtl/nes_receiver.sv
// nes_receiver: polls an NES pad (latch, 8 clocked bits) and presents an active-high button word.
// Define NES_CONFIRM_EN to update buttons only after two consecutive identical reads.
module nes_receiver #(
  parameter int LATCH_TICKS = 300,
  parameter int HALF_TICKS  = 150
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       poll,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       busy
);
  localparam int MAXT = LATCH_TICKS > HALF_TICKS ? LATCH_TICKS : HALF_TICKS;
  localparam int CW = $clog2(MAXT + 1);
  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift;
  logic last;
`ifdef NES_CONFIRM_EN
  logic [7:0] prev;
`endif
  always_comb begin
    last = cnt == ((state == LATCH) ? CW'(LATCH_TICKS - 1) : CW'(HALF_TICKS - 1));
    next = state;
    case (state)
      IDLE:    next = poll ? LATCH : IDLE;
      LATCH:   next = last ? LOW : LATCH;
      LOW:     next = last ? ((idx == 3'd7) ? DONE : HIGH) : LOW;
      HIGH:    next = last ? LOW : HIGH;
      default: next = IDLE;
    endcase
  end
  // Line outputs are registered from the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      nes_latch <= 1'b0;
      nes_clk   <= 1'b0;
      buttons   <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
`ifdef NES_CONFIRM_EN
      prev      <= '0;
`endif
    end else begin
      state     <= next;
      cnt       <= (state == IDLE || state == DONE || last) ? '0 : cnt + 1'b1;
      nes_latch <= next == LATCH;
      nes_clk   <= next == HIGH;
      busy      <= next != IDLE;
      if (state == LOW && last) begin
        shift[3'd7 - idx] <= nes_data;
        idx <= idx + 1'b1;
      end
`ifdef NES_CONFIRM_EN
      valid <= state == DONE && shift == prev;
      if (state == DONE) begin
        prev <= shift;
        if (shift == prev) buttons <= ~shift;
      end
`else
      valid <= state == DONE;
      if (state == DONE) buttons <= ~shift;
`endif
    end
  end
endmodule
